rr_decode_sel: RTL and testbench
================================

// Module: rr_decode_sel
// PURPOSE
//  Four-way round-robin grant sequencer; drives the 2-to-4 decoder's
//   select (A) and enable (E) inputs.
//  Arbitrates four request lines and holds the grant until it is released
//   or times out.
//  Presents the winner as a binary index plus enable.
//  The downstream decoder turns index plus enable into a one-hot strobe
//   (Y) for the owning channel.
// PARAMETERS
//  MAX_HOLD  16  max cycles a grant may persist; 0 disables timeout
//  CW        8   hold-counter width; MAX_HOLD must be < 2**CW
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  reset, asynchronous, active-low
//  en         in   1  arbitration enable; low blocks new grants only
//  req        in   4  request per channel, level, held until served
//  sel        out  2  granted channel index -> decoder A
//  sel_en     out  1  grant valid -> decoder E
//  busy       out  1  high in GRANT and GAP states
//  timeout    out  1  one-cycle pulse when a grant is force-ended
// BEHAVIOUR
//  Reset (async assert, sync deassert by the integrator):
//   - outputs: sel=0, sel_en=0, busy=0, timeout=0
//   - internal: state=IDLE, ptr=0, hold_cnt=0
//  All outputs are registered. No combinational path from req to sel or sel_en.
//  States: IDLE, GRANT, GAP.
//  IDLE:
//   - If en=1 and req!=0, pick the first set bit scanning ptr, ptr+1, ... (mod 4).
//   - Next cycle: state=GRANT, sel=winner, sel_en=1, hold_cnt=1.
//   - Latency: req seen at edge n -> sel_en=1 after edge n+1.
//   - If en=0 or req=0, stay in IDLE with sel_en=0 and sel unchanged.
//  GRANT:
//   - Release when req[sel]=0 -> go to GAP.
//   - Timeout when MAX_HOLD!=0, hold_cnt==MAX_HOLD and req[sel] still 1
//     -> go to GAP, timeout=1 for exactly one cycle.
//   - Otherwise hold_cnt increments (saturating at 2**CW-1); sel is stable.
//   - Release and timeout in the same cycle -> release wins, timeout stays 0.
//   - en falling during GRANT does not end the grant.
//   - Requests for other channels are ignored while granted.
//  GAP (exactly one cycle):
//   - sel_en=0, sel holds its value.
//   - ptr = sel+1 mod 4 (3 wraps to 0).
//   - Next state is IDLE.
//   - Guarantees a dead cycle between grants, so the decoder never sees
//     two adjacent different one-hots.
//  Fairness: a channel that just finished has lowest priority next round.
//   With all four held, order is 0,1,2,3,0...
//  Grant-to-grant minimum spacing is 3 cycles (GRANT >= 1, GAP, IDLE).
//  rst_n low mid-grant: sel_en=0 immediately (async), ptr returns to 0,
//   no timeout pulse.
//  busy = (state != IDLE), registered with the state.
// STRUCTURE
//  Shared header arb_defs.vh holds:
//   - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GAP=2'd2
//   - NUM_CH=4 and IDX_W=2
//   - included by this block and the bench
//  One sub-module, rr_pick4:
//   - combinational rotating priority picker
//   - inputs: req[3:0], ptr[1:0]
//   - outputs: idx[1:0], any
//  The top level holds the FSM, hold counter, ptr and output registers.
// TESTING
//  1. req=4'b0100 at cycle 2 with en=1
//     -> sel=2, sel_en=1 from cycle 3.
//     Drop req at cycle 6 -> sel_en=0 at cycle 7, busy=0 at cycle 8.
//  2. req=4'b1111 held, each owner drops its req 3 cycles after grant,
//     re-raises after GAP
//     -> grant sequence 0,1,2,3,0, each separated by one sel_en=0 cycle.
//  3. MAX_HOLD=4, req[1] stuck high
//     -> sel_en high 4 cycles, timeout=1 for 1 cycle, GAP.
//     If req[3] is also high, the next grant is 3.
//  4. MAX_HOLD=4, req[1] drops on the same edge hold_cnt==4
//     -> GAP entered, timeout stays 0.
//  5. en=0 with req=4'b0011 for 10 cycles -> sel_en=0 throughout.
//     en=1 -> sel=0 granted next cycle.
//     en=0 mid-grant -> grant persists until release.
//  6. rst_n pulsed low during GRANT with sel=3
//     -> sel_en, busy, sel drop to 0 asynchronously.
//     After release, req=4'b1001 -> grant 0 (ptr reset).

Source files
------------

// File: rtl/rr_decode_sel_pkg.sv
// Shared definitions for the round-robin grant sequencer: state encodings,
// channel count and index width, used by the RTL and its bench.
package rr_decode_sel_pkg;

    localparam int NUM_CH = 4;
    localparam int IDX_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arbState_e;

    // Channel after the one given, wrapping 3 -> 0.
    function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_decode_sel_pick4.sv
// Combinational rotating-priority picker: first set request scanning from ptr
// upward, modulo four.
module rr_pick4
    import rr_decode_sel_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              any_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        idx_o = ptr_i;
        found = 1'b0;
        cand  = ptr_i;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = ptr_i + IDX_W'(i);
            if (!found && req_i[cand]) begin
                idx_o = cand;
                found = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/rr_decode_sel.sv
// Four-way round-robin grant sequencer feeding a 2-to-4 decoder (sel -> A,
// sel_en -> E); grants are held until release or timeout, then one dead cycle.
module rr_decode_sel
    import rr_decode_sel_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] req_i,
    output logic [IDX_W-1:0]  sel_o,
    output logic              sel_en_o,
    output logic              busy_o,
    output logic              timeout_o
);

    arbState_e        state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [CW-1:0]    holdCnt_q, holdCnt_d;
    logic             selEn_q, selEn_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic [IDX_W-1:0] pickIdx;
    logic             pickAny;
    logic             holdExpired;

    rr_pick4 u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .idx_o (pickIdx),
        .any_o (pickAny)
    );

    assign holdExpired = (MAX_HOLD != 0) && (holdCnt_q == CW'(MAX_HOLD));

    // Release is tested before timeout so a simultaneous drop never pulses timeout.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        holdCnt_d = holdCnt_q;
        selEn_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_i && pickAny) begin
                    state_d   = ST_GRANT;
                    sel_d     = pickIdx;
                    selEn_d   = 1'b1;
                    holdCnt_d = CW'(1);
                end
            end
            ST_GRANT: begin
                if (!req_i[sel_q]) begin
                    state_d = ST_GAP;
                end else if (holdExpired) begin
                    state_d   = ST_GAP;
                    timeout_d = 1'b1;
                end else begin
                    selEn_d = 1'b1;
                    if (holdCnt_q != {CW{1'b1}})
                        holdCnt_d = holdCnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
                ptr_d   = nextIdx(sel_q);
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            holdCnt_q <= '0;
            selEn_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            holdCnt_q <= holdCnt_d;
            selEn_q   <= selEn_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel_o     = sel_q;
    assign sel_en_o  = selEn_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_decode_sel.sv
// Directed bench for rr_decode_sel: one instance with default hold limit and
// one with MAX_HOLD=4 for the timeout cases, sharing clock and reset.
module tb_rr_decode_sel;
    import rr_decode_sel_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;

    logic              enA = 1'b0;
    logic [NUM_CH-1:0] reqA = '0;
    logic [IDX_W-1:0]  selA;
    logic              selEnA, busyA, timeoutA;

    logic              enB = 1'b0;
    logic [NUM_CH-1:0] reqB = '0;
    logic [IDX_W-1:0]  selB;
    logic              selEnB, busyB, timeoutB;

    int vectorCount = 0;
    int missCount   = 0;

    always #5 clk = ~clk;

    rr_decode_sel dutA (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .en_i      (enA),
        .req_i     (reqA),
        .sel_o     (selA),
        .sel_en_o  (selEnA),
        .busy_o    (busyA),
        .timeout_o (timeoutA)
    );

    rr_decode_sel #(.MAX_HOLD(4), .CW(8)) dutB (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .en_i      (enB),
        .req_i     (reqB),
        .sel_o     (selB),
        .sel_en_o  (selEnB),
        .busy_o    (busyB),
        .timeout_o (timeoutB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state of both instances
        doReset();
        checkOutput("rst selA", 32'(selA), 0);
        checkOutput("rst selEnA", 32'(selEnA), 0);
        checkOutput("rst busyA", 32'(busyA), 0);
        checkOutput("rst timeoutA", 32'(timeoutA), 0);
        checkOutput("rst selEnB", 32'(selEnB), 0);
        checkOutput("rst busyB", 32'(busyB), 0);

        // Single request on channel 2, held four cycles then dropped
        enA = 1'b1; reqA = 4'b0100;
        applyStimulus();
        checkOutput("t1 grant sel", 32'(selA), 2);
        checkOutput("t1 grant en", 32'(selEnA), 1);
        checkOutput("t1 grant busy", 32'(busyA), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t1 hold en", 32'(selEnA), 1);
            checkOutput("t1 hold sel", 32'(selA), 2);
        end
        reqA = 4'b0000;
        applyStimulus();
        checkOutput("t1 gap en", 32'(selEnA), 0);
        checkOutput("t1 gap busy", 32'(busyA), 1);
        checkOutput("t1 gap sel", 32'(selA), 2);
        applyStimulus();
        checkOutput("t1 idle busy", 32'(busyA), 0);
        checkOutput("t1 idle en", 32'(selEnA), 0);
        checkOutput("t1 idle sel", 32'(selA), 2);

        // All four requesting, each owner releases after three cycles
        doReset();
        enA = 1'b1; reqA = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            checkOutput("t2 grant sel", 32'(selA), 32'(k % 4));
            checkOutput("t2 grant en", 32'(selEnA), 1);
            applyStimulus();
            applyStimulus();
            checkOutput("t2 hold en", 32'(selEnA), 1);
            checkOutput("t2 hold sel", 32'(selA), 32'(k % 4));
            reqA[k % 4] = 1'b0;
            applyStimulus();
            checkOutput("t2 gap en", 32'(selEnA), 0);
            reqA = 4'b1111;
            applyStimulus();
            checkOutput("t2 idle en", 32'(selEnA), 0);
            checkOutput("t2 idle busy", 32'(busyA), 0);
        end
        reqA = 4'b0000; enA = 1'b0;

        // Stuck request on channel 1 times out after four cycles, then 3 wins
        enB = 1'b1; reqB = 4'b1010;
        applyStimulus();
        checkOutput("t3 grant sel", 32'(selB), 1);
        checkOutput("t3 grant en", 32'(selEnB), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t3 hold en", 32'(selEnB), 1);
            checkOutput("t3 hold timeout", 32'(timeoutB), 0);
        end
        applyStimulus();
        checkOutput("t3 gap en", 32'(selEnB), 0);
        checkOutput("t3 gap timeout", 32'(timeoutB), 1);
        checkOutput("t3 gap busy", 32'(busyB), 1);
        applyStimulus();
        checkOutput("t3 idle timeout", 32'(timeoutB), 0);
        checkOutput("t3 idle busy", 32'(busyB), 0);
        applyStimulus();
        checkOutput("t3 next sel", 32'(selB), 3);
        checkOutput("t3 next en", 32'(selEnB), 1);
        reqB = 4'b0000;
        applyStimulus();
        applyStimulus();

        // Release on the same edge the hold limit is reached
        reqB = 4'b0010;
        applyStimulus();
        checkOutput("t4 grant sel", 32'(selB), 1);
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("t4 hold en", 32'(selEnB), 1);
        reqB = 4'b0000;
        applyStimulus();
        checkOutput("t4 gap en", 32'(selEnB), 0);
        checkOutput("t4 gap timeout", 32'(timeoutB), 0);
        checkOutput("t4 gap busy", 32'(busyB), 1);
        applyStimulus();
        enB = 1'b0;

        // Enable gating: blocks new grants only
        doReset();
        enA = 1'b0; reqA = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkOutput("t5 blocked en", 32'(selEnA), 0);
        end
        enA = 1'b1;
        applyStimulus();
        checkOutput("t5 grant sel", 32'(selA), 0);
        checkOutput("t5 grant en", 32'(selEnA), 1);
        enA = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t5 persist en", 32'(selEnA), 1);
            checkOutput("t5 persist sel", 32'(selA), 0);
        end
        reqA = 4'b0010;
        applyStimulus();
        checkOutput("t5 gap en", 32'(selEnA), 0);
        applyStimulus();
        checkOutput("t5 idle busy", 32'(busyA), 0);
        applyStimulus();
        checkOutput("t5 gated en", 32'(selEnA), 0);
        reqA = 4'b0000;

        // Asynchronous reset mid-grant on channel 3 (ptr is 1 beforehand)
        enA = 1'b1; reqA = 4'b1000;
        applyStimulus();
        checkOutput("t6 grant sel", 32'(selA), 3);
        checkOutput("t6 grant en", 32'(selEnA), 1);
        applyStimulus();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6 async en", 32'(selEnA), 0);
        checkOutput("t6 async busy", 32'(busyA), 0);
        checkOutput("t6 async sel", 32'(selA), 0);
        checkOutput("t6 async timeout", 32'(timeoutA), 0);
        reqA = 4'b0000;
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        reqA = 4'b1001;
        applyStimulus();
        checkOutput("t6 after sel", 32'(selA), 0);
        checkOutput("t6 after en", 32'(selEnA), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
